// File: rtl/clip_pkg.sv
// Shared widths, sample types and the magnitude helper for the sample clipper.
package clip_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int THR_W = 15;
  localparam int CNT_W = 16;

  typedef logic signed [OUT_W-1:0] sample_t;
  typedef logic signed [IN_W-1:0]  acc_t;

  // Absolute value widened by one bit so that -2^31 maps to +2^31 exactly.
  function automatic logic [IN_W:0] mag33(input acc_t x);
    logic [IN_W:0] ext_v;
    ext_v = {x[IN_W-1], x};
    if (x[IN_W-1]) begin
      return ~ext_v + 33'd1;
    end else begin
      return ext_v;
    end
  endfunction

endpackage

// File: rtl/clip_core.sv
// Combinational transfer function: magnitude clip (hard) or soft knee when
// SOFT_CLIP_EN is defined. Reports whether the sample was modified.
module clip_core
  import clip_pkg::*;
(
  input  acc_t             x,
  input  logic [THR_W-1:0] thr,
  output sample_t          result,
  output logic             clipped
);

  logic [IN_W:0]      mag_s;
  logic [THR_W-1:0]   mag_out_s;
  sample_t            mag16_s;
`ifdef SOFT_CLIP_EN
  logic [THR_W-1:0]   knee_s;
  logic [THR_W+1:0]   three_k_s;
  logic [OUT_W-1:0]   diff_s;
`endif

  // Shape the magnitude, then restore the sign; output stays within +/-thr.
  always_comb begin
    mag_s     = mag33(x);
    mag_out_s = thr;
`ifdef SOFT_CLIP_EN
    knee_s    = thr >> 1;
    three_k_s = {2'b00, knee_s} + {1'b0, knee_s, 1'b0};
    diff_s    = mag_s[OUT_W-1:0] - {1'b0, knee_s};
    if (mag_s <= {18'd0, knee_s}) begin
      mag_out_s = mag_s[THR_W-1:0];
    end else if (mag_s < {16'd0, three_k_s}) begin
      mag_out_s = knee_s + 15'(diff_s >> 1);
    end else begin
      mag_out_s = thr;
    end
`else
    if (mag_s > {18'd0, thr}) begin
      mag_out_s = thr;
    end else begin
      mag_out_s = mag_s[THR_W-1:0];
    end
`endif
    mag16_s = sample_t'({1'b0, mag_out_s});
    if (x[IN_W-1]) begin
      result = -mag16_s;
    end else begin
      result = mag16_s;
    end
    clipped = (mag_s != {18'd0, mag_out_s});
  end

endmodule

// File: rtl/sample_clipper.sv
// Two-stage valid/ready sample clipper: S1 captures sample and threshold,
// S2 holds the shaped result. Soft-knee shaping selected by SOFT_CLIP_EN.
module sample_clipper
  import clip_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [THR_W-1:0] thr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             clip_active,
  input  logic             clear_count,
  output logic [CNT_W-1:0] clip_count
);

  logic             s1_valid_r;
  acc_t             s1_data_r;
  logic [THR_W-1:0] s1_thr_r;
  logic             s2_adv_s;
  logic             cnt_inc_s;
  sample_t          core_result_s;
  logic             core_clipped_s;

  clip_core u_core (
    .x       (s1_data_r),
    .thr     (s1_thr_r),
    .result  (core_result_s),
    .clipped (core_clipped_s)
  );

  // Handshake: S2 frees when empty or draining; S1 frees when empty or moving on.
  always_comb begin
    s2_adv_s  = !out_valid || out_ready;
    in_ready  = !s1_valid_r || s2_adv_s;
    cnt_inc_s = out_valid && out_ready && clip_active;
  end

  // S1 register: sample and its threshold are captured together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      s1_thr_r   <= '0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r <= acc_t'(in_data);
        s1_thr_r  <= thr;
      end
    end
  end

  // S2 register: holds the shaped sample stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      clip_active <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data    <= core_result_s;
        clip_active <= core_clipped_s;
      end
    end
  end

  // Saturating count of modified samples actually handed downstream; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (clear_count) begin
      clip_count <= '0;
    end else if (cnt_inc_s && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sample_clipper.sv
// Directed self-checking bench for sample_clipper (hard or SOFT_CLIP_EN build).
module tb_sample_clipper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [14:0] thr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        clip_active;
  logic        clear_count;
  logic [15:0] clip_count;

  int checks = 0;
  int failures = 0;
  int vin [8];
  int vexp [8];
  logic vclip [8];
  int got [$];

  sample_clipper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .thr         (thr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .clip_active (clip_active),
    .clear_count (clear_count),
    .clip_count  (clip_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [15:0] obs, input int exp);
    logic [15:0] e;
    e = 16'(exp);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(e));
    end
  endtask

  // Back-to-back stream of n samples with out_ready high; outputs two edges later.
  task automatic run_stream(input string tag, input int n);
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        in_valid = 1'b1;
        in_data  = vin[c];
      end else begin
        in_valid = 1'b0;
        in_data  = 32'd0;
      end
      step();
      if (c >= 1) begin
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk_data({tag, "_data"}, out_data, vexp[c-1]);
        chk({tag, "_clip"}, int'(clip_active), int'(vclip[c-1]));
      end
    end
    step();
    chk({tag, "_drain"}, int'(out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_data = 32'd0; thr = 15'd0;
    out_ready = 1'b1; clear_count = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk_data("rst_out_data", out_data, 0);
    chk("rst_clip_active", int'(clip_active), 0);
    chk("rst_clip_count", int'(clip_count), 0);
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    step();

    // Hard reference stream at thr=16384 including -2^31.
    thr = 15'd16384;
    vin[0] = 1000; vin[1] = 20000; vin[2] = -40000; vin[3] = int'(32'h8000_0000);
`ifdef SOFT_CLIP_EN
    vexp[0] = 1000; vexp[1] = 14096; vexp[2] = -16384; vexp[3] = -16384;
`else
    vexp[0] = 1000; vexp[1] = 16384; vexp[2] = -16384; vexp[3] = -16384;
`endif
    vclip[0] = 1'b0; vclip[1] = 1'b1; vclip[2] = 1'b1; vclip[3] = 1'b1;
    run_stream("thr16k", 4);
    chk("thr16k_count", int'(clip_count), 3);

    // Threshold change applies only to later samples; -32768 never produced.
    thr = 15'd32767;
    vin[0] = -32768; vin[1] = 32767; vin[2] = -32767;
`ifdef SOFT_CLIP_EN
    vexp[0] = -24575; vexp[1] = 24575; vexp[2] = -24575;
    vclip[0] = 1'b1; vclip[1] = 1'b1; vclip[2] = 1'b1;
`else
    vexp[0] = -32767; vexp[1] = 32767; vexp[2] = -32767;
    vclip[0] = 1'b1; vclip[1] = 1'b0; vclip[2] = 1'b0;
`endif
    run_stream("thrmax", 3);

    // Soft-knee reference (hard build clips only the last one).
    thr = 15'd16384;
    vin[0] = 8192; vin[1] = 12288; vin[2] = -12288; vin[3] = 30000;
`ifdef SOFT_CLIP_EN
    vexp[0] = 8192; vexp[1] = 10240; vexp[2] = -10240; vexp[3] = 16384;
    vclip[0] = 1'b0; vclip[1] = 1'b1; vclip[2] = 1'b1; vclip[3] = 1'b1;
`else
    vexp[0] = 8192; vexp[1] = 12288; vexp[2] = -12288; vexp[3] = 16384;
    vclip[0] = 1'b0; vclip[1] = 1'b0; vclip[2] = 1'b0; vclip[3] = 1'b1;
`endif
    run_stream("knee", 4);

    // thr=0 forces zero output.
    clear_count = 1'b1; step(); clear_count = 1'b0;
    chk("clear_count", int'(clip_count), 0);
    thr = 15'd0;
    vin[0] = 5; vin[1] = 0;
    vexp[0] = 0; vexp[1] = 0;
    vclip[0] = 1'b1; vclip[1] = 1'b0;
    run_stream("thr0", 2);
    chk("thr0_count", int'(clip_count), 1);

    // Backpressure: out_ready low for 4 cycles with 3 samples offered.
    thr = 15'd1000;
    vin[0] = 100; vin[1] = -200; vin[2] = 3000;
    begin
      int si;
      si = 0;
      got.delete();
      for (int it = 0; it < 10; it++) begin
        logic acc;
        logic xfer;
        out_ready = (it >= 4);
        in_valid  = (si < 3);
        in_data   = (si < 3) ? vin[si] : 32'd0;
        #1;
        if (it == 2) begin
          chk("bp_in_ready_low", int'(in_ready), 0);
          chk_data("bp_hold_data", out_data, 100);
        end
        if (it == 3) begin
          chk("bp_hold_valid", int'(out_valid), 1);
          chk_data("bp_stable_data", out_data, 100);
        end
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) got.push_back(int'($signed(out_data)));
        step();
        if (acc) si++;
      end
      in_valid = 1'b0;
      chk("bp_count", got.size(), 3);
      chk("bp_s0", (got.size() > 0) ? got[0] : 99999, 100);
      chk("bp_s1", (got.size() > 1) ? got[1] : 99999, -200);
      chk("bp_s2", (got.size() > 2) ? got[2] : 99999, 1000);
    end
    out_ready = 1'b1;

    // Saturation: more than 65535 clipped transfers.
    clear_count = 1'b1; step(); clear_count = 1'b0;
    thr = 15'd0;
    in_valid = 1'b1; in_data = 32'd1;
    for (int i = 0; i < 65540; i++) step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("sat_count", int'(clip_count), 65535);
    clear_count = 1'b1; step(); clear_count = 1'b0;
    chk("sat_clear", int'(clip_count), 0);

    // Plain increment, then clear coinciding with a clipped transfer.
    in_valid = 1'b1; in_data = 32'd7; step();
    in_valid = 1'b0; step(); step();
    chk("inc_count", int'(clip_count), 1);
    in_valid = 1'b1; in_data = 32'd9; step();
    in_valid = 1'b0; step();
    chk("prio_valid", int'(out_valid), 1);
    chk("prio_clip", int'(clip_active), 1);
    clear_count = 1'b1; step(); clear_count = 1'b0;
    chk("prio_count", int'(clip_count), 0);

    // Reset with samples in flight.
    in_valid = 1'b1; in_data = 32'd100; step();
    in_data = 32'd200; step();
    in_data = 32'd300; step();
    in_valid = 1'b0;
    chk("pre_rst_count", int'(clip_count), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk_data("arst_out_data", out_data, 0);
    chk("arst_clip", int'(clip_active), 0);
    chk("arst_count", int'(clip_count), 0);
    step();
    rst_n = 1'b1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_stale", int'(out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
